// File: rtl/biu_pkg.sv
// biu_pkg: shared widths, bus-cycle state encoding and byte-lane names for the
// biu_ciclo_bus bus interface unit.
package biu_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int WCNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        LANE_LO   = 2'd0,
        LANE_HI   = 2'd1,
        LANE_BOTH = 2'd2
    } lane_e;

endpackage

// File: rtl/biu_alineador.sv
// biu_alineador: combinational byte-lane steering for one bus sub-cycle
// (BHE_N, write-data placement, read-data extraction).
module biu_alineador
    import biu_pkg::*;
(
    input  logic              i_a0,
    input  logic              i_word,
    input  logic              i_sub,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_bhe_n,
    output logic [DATA_W-1:0] o_dout,
    output logic [DATA_W-1:0] o_rdata
);

    lane_e      w_lane;
    logic [7:0] w_wbyte;

    // A split word uses the odd (high) lane first, then the even (low) lane.
    always_comb begin
        w_lane = LANE_LO;
        if (i_word && i_a0) begin
            if (i_sub) w_lane = LANE_LO;
            else       w_lane = LANE_HI;
        end else if (i_word) begin
            w_lane = LANE_BOTH;
        end else if (i_a0) begin
            w_lane = LANE_HI;
        end else begin
            w_lane = LANE_LO;
        end
    end

    assign w_wbyte = (i_word && i_sub) ? i_wdata[15:8] : i_wdata[7:0];

    // Lane-dependent strobes and data placement.
    always_comb begin
        o_bhe_n = 1'b1;
        o_dout  = {DATA_W{1'b0}};
        o_rdata = {DATA_W{1'b0}};
        case (w_lane)
            LANE_BOTH: begin
                o_bhe_n = 1'b0;
                o_dout  = i_wdata;
                o_rdata = i_din;
            end
            LANE_HI: begin
                o_bhe_n = 1'b0;
                o_dout  = {w_wbyte, 8'h00};
                o_rdata = {8'h00, i_din[15:8]};
            end
            LANE_LO: begin
                o_bhe_n = 1'b1;
                o_dout  = {8'h00, w_wbyte};
                o_rdata = {8'h00, i_din[7:0]};
            end
            default: begin
                o_bhe_n = 1'b1;
                o_dout  = {DATA_W{1'b0}};
                o_rdata = {DATA_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/biu_ciclo_bus.sv
// biu_ciclo_bus: 8086-style T1..T4/TW memory bus cycle sequencer.
// Optional macro BUS_TIMEOUT_EN bounds wait states to MAX_WAIT and flags ERR.
module biu_ciclo_bus
    import biu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic              WORD,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic [ADDR_W-1:0] A,
    output logic              ALE,
    output logic              BHE_N,
    output logic              RD_N,
    output logic              WR_N,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_OE,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              READY
);

    state_e            r_state, w_state_nxt;
    logic              r_we, r_word, r_a0, r_sub;
    logic [DATA_W-1:0] r_wdata, r_rdata, r_dout;
    logic [7:0]        r_lo;
    logic [ADDR_W-1:0] r_a;
    logic              r_busy, r_done, r_err, r_ale, r_bhe_n, r_rd_n, r_wr_n, r_oe;

    logic              w_idle, w_enter_t1, w_ready_hit, w_timeout, w_wait_max;
    logic              w_split, w_last, w_strobe_nxt;
    logic              w_a0_al, w_word_al, w_sub_al, w_we_al, w_bhe_n;
    logic [DATA_W-1:0] w_wdata_al, w_dout, w_rd;
    logic [ADDR_W-1:0] w_a_nxt;

`ifdef BUS_TIMEOUT_EN
    localparam logic [WCNT_W-1:0] MAX_WAIT_C = WCNT_W'(MAX_WAIT);
    logic [WCNT_W-1:0] r_wait_cnt;

    // Wait counter holds the number of the TW state currently in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                   r_wait_cnt <= 8'd0;
        else if (r_state == ST_T3) r_wait_cnt <= 8'd1;
        else if (r_state == ST_TW) r_wait_cnt <= r_wait_cnt + 8'd1;
        else                       r_wait_cnt <= r_wait_cnt;
    end

    assign w_wait_max = (r_state == ST_TW) && (r_wait_cnt == MAX_WAIT_C);
`else
    logic w_unused_param;
    assign w_unused_param = (MAX_WAIT > 0);
    assign w_wait_max     = 1'b0;
`endif

    // In IDLE the lane steering looks at the live request so T1 can be loaded on accept.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_a0_al    = w_idle ? ADDR[0] : r_a0;
    assign w_word_al  = w_idle ? WORD    : r_word;
    assign w_we_al    = w_idle ? WE      : r_we;
    assign w_wdata_al = w_idle ? WDATA   : r_wdata;
    assign w_sub_al   = (r_state == ST_T4) ? 1'b1 : (w_idle ? 1'b0 : r_sub);
    assign w_a_nxt    = w_idle ? ADDR : (r_a + 20'd1);
    assign w_split    = r_word & r_a0;
    assign w_last     = ~w_split | r_sub | w_timeout;
    assign w_enter_t1 = (w_state_nxt == ST_T1) && (r_state != ST_T1);
    assign w_strobe_nxt = (w_state_nxt == ST_T2) || (w_state_nxt == ST_T3) ||
                          (w_state_nxt == ST_TW) || (w_state_nxt == ST_T4);

    biu_alineador u_alineador (
        .i_a0    (w_a0_al),
        .i_word  (w_word_al),
        .i_sub   (w_sub_al),
        .i_wdata (w_wdata_al),
        .i_din   (D_IN),
        .o_bhe_n (w_bhe_n),
        .o_dout  (w_dout),
        .o_rdata (w_rd)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ready_hit = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (REQ) w_state_nxt = ST_T1;
                else     w_state_nxt = ST_IDLE;
            end
            ST_T1: w_state_nxt = ST_T2;
            ST_T2: w_state_nxt = ST_T3;
            ST_T3: begin
                if (READY) begin
                    w_state_nxt = ST_T4;
                    w_ready_hit = 1'b1;
                end else begin
                    w_state_nxt = ST_TW;
                end
            end
            ST_TW: begin
                if (READY) begin
                    w_state_nxt = ST_T4;
                    w_ready_hit = 1'b1;
                end else if (w_wait_max) begin
                    w_state_nxt = ST_T4;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = ST_TW;
                end
            end
            ST_T4: begin
                if (r_done) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_T1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Request latch and sub-cycle index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_word  <= 1'b0;
            r_a0    <= 1'b0;
            r_wdata <= 16'h0000;
            r_sub   <= 1'b0;
        end else if (w_idle && REQ) begin
            r_we    <= WE;
            r_word  <= WORD;
            r_a0    <= ADDR[0];
            r_wdata <= WDATA;
            r_sub   <= 1'b0;
        end else if ((r_state == ST_T4) && !r_done) begin
            r_sub   <= 1'b1;
        end else begin
            r_sub   <= r_sub;
        end
    end

    // Bus pins: address/lane loaded on T1 entry, strobes span T2 through T4.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a     <= 20'h00000;
            r_bhe_n <= 1'b1;
            r_dout  <= 16'h0000;
            r_ale   <= 1'b0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_oe    <= 1'b0;
        end else begin
            if (w_enter_t1) begin
                r_a     <= w_a_nxt;
                r_bhe_n <= w_bhe_n;
                if (w_we_al) r_dout <= w_dout;
                else         r_dout <= r_dout;
            end else begin
                r_a     <= r_a;
                r_bhe_n <= r_bhe_n;
                r_dout  <= r_dout;
            end
            r_ale  <= (w_state_nxt == ST_T1);
            r_rd_n <= ~(w_strobe_nxt & ~r_we);
            r_wr_n <= ~(w_strobe_nxt & r_we);
            r_oe   <= w_strobe_nxt & r_we;
        end
    end

    // Handshake towards the execution side.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_T4) && w_last;
            r_err  <= (w_state_nxt == ST_T4) && w_timeout;
        end
    end

    // Read capture; the first half of a split word waits in r_lo.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lo    <= 8'h00;
            r_rdata <= 16'h0000;
        end else if (w_ready_hit && !r_we) begin
            if (w_split && !r_sub) r_lo    <= w_rd[7:0];
            else if (w_split)      r_rdata <= {w_rd[7:0], r_lo};
            else                   r_rdata <= w_rd;
        end else begin
            r_lo    <= r_lo;
            r_rdata <= r_rdata;
        end
    end

    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign ERR   = r_err;
    assign RDATA = r_rdata;
    assign A     = r_a;
    assign ALE   = r_ale;
    assign BHE_N = r_bhe_n;
    assign RD_N  = r_rd_n;
    assign WR_N  = r_wr_n;
    assign D_OUT = r_dout;
    assign D_OE  = r_oe;

endmodule

// File: tb/tb_biu_ciclo_bus.sv
// tb_biu_ciclo_bus: table-driven, hand-written and randomized checks of
// biu_ciclo_bus against a cycle-timeline model of the bus protocol.
module tb_biu_ciclo_bus;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE, WORD, READY;
    logic [19:0] ADDR;
    logic [15:0] WDATA, D_IN;
    logic        BUSY, DONE, ERR, ALE, BHE_N, RD_N, WR_N, D_OE;
    logic [15:0] RDATA, D_OUT;
    logic [19:0] A;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] g_rdata;

    typedef struct {
        logic        we;
        logic        word;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] din0;
        logic [15:0] din1;
        int          w0;
        int          w1;
        logic [15:0] exp_rdata;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    biu_ciclo_bus #(.MAX_WAIT(3)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .WORD(WORD), .ADDR(ADDR),
        .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
        .A(A), .ALE(ALE), .BHE_N(BHE_N), .RD_N(RD_N), .WR_N(WR_N),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .READY(READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: sub-cycle k starts at cycle start[k] and lasts 4 + w[k] cycles.
    task automatic run_access(input logic we, input logic word, input logic [19:0] addr,
                              input logic [15:0] wdata, input logic [15:0] din0,
                              input logic [15:0] din1, input int w0, input int w1,
                              input bit glitch, output int done_cyc,
                              output logic [15:0] rdata_obs);
        int          n, total, i, p, ndone;
        logic [19:0] sa [2];
        logic [15:0] dexp [2];
        logic [15:0] mask [2];
        logic [15:0] din [2];
        logic        bhe [2];
        int          w [2];
        int          start [2];
        logic [63:0] act, exp;
        logic        strobe;
        logic [7:0]  b;
        n        = (word && addr[0]) ? 2 : 1;
        sa[0]    = addr;
        sa[1]    = addr + 20'd1;
        w[0]     = w0;
        w[1]     = w1;
        din[0]   = din0;
        din[1]   = din1;
        start[0] = 1;
        start[1] = 5 + w0;
        total    = 4 + w0 + ((n == 2) ? 4 + w1 : 0);
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? wdata[7:0] : wdata[15:8];
            if (n == 1 && word) begin
                bhe[k] = 1'b0; mask[k] = 16'hFFFF; dexp[k] = wdata;
            end else if (sa[k][0]) begin
                bhe[k] = 1'b0; mask[k] = 16'hFF00; dexp[k] = {b, 8'h00};
            end else begin
                bhe[k] = 1'b1; mask[k] = 16'h00FF; dexp[k] = {8'h00, b};
            end
        end
        if (!we) begin
            if (n == 2)       g_rdata = {din1[7:0], din0[15:8]};
            else if (word)    g_rdata = din0;
            else if (addr[0]) g_rdata = {8'h00, din0[15:8]};
            else              g_rdata = {8'h00, din0[7:0]};
        end
        @(negedge CLK);
        REQ = 1'b1; WE = we; WORD = word; ADDR = addr; WDATA = wdata;
        READY = 1'b1; D_IN = din0;
        done_cyc = -1;
        ndone    = 0;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge CLK);
            REQ = glitch && (c == 2 || c == 3);
            if (glitch) begin
                ADDR = ~addr;
                WE   = ~we;
            end
            if (DONE) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c <= total) begin
                i      = (n == 2 && c >= start[1]) ? 1 : 0;
                p      = c - start[i];
                READY  = !(p >= 2 && p < 2 + w[i]);
                D_IN   = din[i];
                strobe = (p >= 1);
                exp = {20'd0, (p == 0), !(strobe && !we), !(strobe && we), (strobe && we),
                       bhe[i], (c == total), 1'b1, 1'b0, sa[i], we ? dexp[i] : 16'h0000};
                act = {20'd0, ALE, RD_N, WR_N, D_OE, BHE_N, DONE, BUSY, ERR, A,
                       we ? (D_OUT & mask[i]) : 16'h0000};
                chk($sformatf("bus a=%h c=%0d", addr, c), act, exp);
            end else begin
                exp = {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0};
                act = {20'd0, ALE, RD_N, WR_N, D_OE, 1'b0, DONE, BUSY, ERR, 36'd0};
                chk($sformatf("idle a=%h c=%0d", addr, c), act, exp);
                if (c == total + 1) chk("rdata", {48'd0, RDATA}, {48'd0, g_rdata});
            end
        end
        chk("one_done", ndone, 1);
        rdata_obs = RDATA;
        REQ = 1'b0; WE = we; ADDR = addr;
    endtask

    initial begin
        int          dc;
        logic [15:0] ro;
        logic        rw, rword;
        logic [19:0] raddr;
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; WORD = 1'b0; ADDR = 20'h0;
        WDATA = 16'h0; D_IN = 16'h0; READY = 1'b1; g_rdata = 16'h0000;
        #1;
        chk("reset", {A, ALE, BHE_N, RD_N, WR_N, D_OE, D_OUT, RDATA, DONE, BUSY, ERR},
            {20'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 20'h12340, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 16'hBEEF, 4};
        vecs[1] = '{1'b1, 1'b0, 20'h0ABCD, 16'h005A, 16'h0000, 16'h0000, 2, 0, 16'hBEEF, 6};
        vecs[2] = '{1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'h3300, 16'h0077, 0, 0, 16'h7733, 8};
        vecs[3] = '{1'b0, 1'b0, 20'h00100, 16'h0000, 16'h1234, 16'h0000, 1, 0, 16'h0034, 5};
        vecs[4] = '{1'b0, 1'b0, 20'h00101, 16'h0000, 16'hAB00, 16'h0000, 0, 0, 16'h00AB, 4};
        vecs[5] = '{1'b1, 1'b1, 20'h00201, 16'hC3D4, 16'h0000, 16'h0000, 1, 0, 16'h00AB, 9};
        vecs[6] = '{1'b1, 1'b1, 20'h00400, 16'h55AA, 16'h0000, 16'h0000, 3, 0, 16'h00AB, 7};
        for (int v = 0; v < 7; v++) begin
            run_access(vecs[v].we, vecs[v].word, vecs[v].addr, vecs[v].wdata, vecs[v].din0,
                       vecs[v].din1, vecs[v].w0, vecs[v].w1, 1'b0, dc, ro);
            chk($sformatf("tbl%0d_done", v), dc, vecs[v].exp_done);
            chk($sformatf("tbl%0d_rdata", v), {48'd0, ro}, {48'd0, vecs[v].exp_rdata});
        end

        // REQ pulses while busy must be dropped, not queued.
        run_access(1'b0, 1'b0, 20'h00333, 16'h0000, 16'h9900, 16'h0000, 1, 0, 1'b1, dc, ro);
        chk("glitch_done", dc, 5);
        chk("glitch_rdata", {48'd0, ro}, {48'd0, 16'h0099});

        // Asynchronous reset in the middle of T2 of a read.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; WORD = 1'b1; ADDR = 20'h54320; READY = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        chk("t2_rd_low", {63'd0, RD_N}, 64'd0);
        RST = 1'b1;
        #1;
        chk("mid_reset", {A, ALE, BHE_N, RD_N, WR_N, D_OE, D_OUT, RDATA, DONE, BUSY, ERR},
            {20'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0});
        @(negedge CLK);
        RST = 1'b0;
        g_rdata = 16'h0000;

`ifdef BUS_TIMEOUT_EN
        // Permanent READY=0 on a split read: three TW states, then DONE+ERR, no second half.
        run_access(1'b0, 1'b1, 20'h00600, 16'h0000, 16'h4321, 16'h0000, 0, 0, 1'b0, dc, ro);
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; WORD = 1'b1; ADDR = 20'h00201; READY = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            REQ   = 1'b0;
            READY = 1'b0;
            chk($sformatf("tmo c=%0d", c), {61'd0, DONE, ERR, BUSY},
                {61'd0, (c == 7), (c == 7), (c <= 7)});
        end
        chk("tmo_rdata", {48'd0, RDATA}, {48'd0, g_rdata});
        READY = 1'b1;
`endif

        for (int r = 0; r < 40; r++) begin
            rw    = 1'($urandom_range(0, 1));
            rword = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) raddr = 20'hFFFFF - 20'($urandom_range(0, 1));
            else                           raddr = 20'($urandom());
            run_access(rw, rword, raddr, 16'($urandom()), 16'($urandom()), 16'($urandom()),
                       $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, dc, ro);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
